// File: rtl/elf_ram_arbiter_if.sv
// Bus bundle between the ELF RAM arbiter and its three requesters plus the RAM macro.
// The arbiter takes the slave modport; the surrounding system takes master.
interface elf_ram_arbiter_if #(
  parameter int AW = 12
);
  logic          dl_active;
  logic          dl_wr;
  logic [24:0]   dl_addr;
  logic [7:0]    dl_data;
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic          dma_ack;
  logic [7:0]    dma_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          cpu_hold;
  logic          dl_overflow;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    input  dma_req, dma_addr,
    output dma_ack, dma_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_hold, dl_overflow,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    output dma_req, dma_addr,
    input  dma_ack, dma_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_hold, dl_overflow,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/elf_ram_arbiter.sv
// Single-port RAM arbiter for the Cosmac ELF: zero-fill sweep after reset,
// ioctl BIN download, then DMA-over-CPU arbitration of one synchronous 8-bit RAM.
module elf_ram_arbiter #(
  parameter int AW = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  elf_ram_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] clr_cnt;
  logic          pend, pend_ovf;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic          overflow_q;
  logic          dma_ack_q, cpu_ack_q, cpu_rd_q;
  logic [7:0]    dma_rdata_q, cpu_rdata_q;
  logic          grant_dma, grant_cpu;
  logic          addr_ovf;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;

  assign addr_ovf = |bus.dl_addr[24:AW];

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    grant_dma = 1'b0;
    grant_cpu = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    unique case (state)
      ST_CLEAR: begin
        // Held in reset the sweep must not write, so the strobe is gated by reset_n.
        ram_we   = reset_n;
        ram_addr = clr_cnt;
        if (bus.dl_active)   state_nx = ST_LOAD;
        else if (&clr_cnt)   state_nx = ST_RUN;
      end
      ST_RUN: begin
        grant_dma = bus.dma_req && !dma_ack_q;
        grant_cpu = !grant_dma && bus.cpu_req && !cpu_ack_q;
        if (bus.dl_active || pend) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (pend) begin
          ram_we = !pend_ovf;
          if (!pend_ovf) begin
            ram_addr  = buf_addr;
            ram_wdata = buf_data;
          end
        end else begin
          grant_dma = bus.dma_req && !dma_ack_q;
        end
        if (!bus.dl_active && !pend && !bus.dl_wr) state_nx = ST_RUN;
      end
      default: state_nx = ST_CLEAR;
    endcase
    if (grant_dma) ram_addr = bus.dma_addr;
    if (grant_cpu) begin
      ram_addr  = bus.cpu_addr;
      ram_we    = bus.cpu_we;
      ram_wdata = bus.cpu_we ? bus.cpu_wdata : 8'h00;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_CLEAR;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt     <= '0;
      pend        <= 1'b0;
      pend_ovf    <= 1'b0;
      overflow_q  <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rd_q    <= 1'b0;
      dma_rdata_q <= 8'h00;
      cpu_rdata_q <= 8'h00;
    end else begin
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      // A strobe in the drain cycle recaptures, keeping back-to-back writes lossless.
      if (bus.dl_wr) begin
        pend     <= 1'b1;
        pend_ovf <= addr_ovf;
      end else if (state == ST_LOAD) begin
        pend <= 1'b0;
      end
      if (state != ST_LOAD && state_nx == ST_LOAD) overflow_q <= 1'b0;
      if (bus.dl_wr && addr_ovf)                   overflow_q <= 1'b1;
      dma_ack_q <= grant_dma;
      cpu_ack_q <= grant_cpu;
      cpu_rd_q  <= grant_cpu && !bus.cpu_we;
      if (dma_ack_q) dma_rdata_q <= bus.ram_rdata;
      if (cpu_rd_q)  cpu_rdata_q <= bus.ram_rdata;
    end
  end

  // NOTE: the download buffer is pure datapath qualified by pend, so it carries no reset.
  always_ff @(posedge clk) begin
    if (bus.dl_wr) begin
      buf_addr <= bus.dl_addr[AW-1:0];
      buf_data <= bus.dl_data;
    end
  end

  assign bus.ram_addr    = ram_addr;
  assign bus.ram_we      = ram_we;
  assign bus.ram_wdata   = ram_wdata;
  assign bus.dma_ack     = dma_ack_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.dma_rdata   = dma_ack_q ? bus.ram_rdata : dma_rdata_q;
  assign bus.cpu_rdata   = cpu_rd_q  ? bus.ram_rdata : cpu_rdata_q;
  assign bus.cpu_hold    = (state != ST_RUN) || (bus.cpu_req && !cpu_ack_q);
  assign bus.dl_overflow = overflow_q;
endmodule
